lsu_mem_bridge: RTL and testbench
=================================

# lsu_mem_bridge

Memory-side stage directly downstream of the load/store functional unit. It accepts the LSU's 64-bit read and write requests, buffers posted stores in a small in-order store buffer, and forwards buffered data to later loads to the same doubleword. It drains the buffer to a single-ported data memory through a request/grant handshake and returns load data to the LSU as a one-cycle valid pulse.

## Interface
Parameters:
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2)
- CNT_BITS, 3, width of sb_count (must hold 0..SB_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- lsu_ren  in  1  load request; LSU holds it and lsu_raddr stable until lsu_rvalid
- lsu_raddr  in  64  load address
- lsu_rvalid  out  1  one-cycle pulse, load data valid
- lsu_rdata  out  64  load data, valid only with lsu_rvalid
- lsu_wen  in  1  store request, single-cycle pulse
- lsu_waddr  in  64  store address
- lsu_wdata  in  64  store data
- lsu_wready  out  1  store buffer can accept a store this cycle
- dmem_req  out  1  memory request; held with payload until dmem_gnt
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  64  memory address, bits [2:0] forced to 0
- dmem_wdata  out  64  write data
- dmem_gnt  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data return, any cycle ≥1 after grant
- dmem_rdata  in  64  read data
- sb_count  out  CNT_BITS  occupied store-buffer entries
- err_overflow  out  1  sticky: a store arrived while lsu_wready = 0

## Operation
- All accesses are 64-bit doublewords. Address match compares bits [63:3]; bits [2:0] are ignored.
- Store buffer: circular FIFO with head/tail pointers and a count.
  - Push when lsu_wen && lsu_wready.
  - Pop when a drain write is granted.
  - lsu_wready = (count < SB_DEPTH), computed from the registered count. A same-cycle pop does not free a slot until the next cycle.
  - lsu_wen while lsu_wready = 0: the store is dropped, err_overflow sets and stays set until reset.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ.
  - IDLE, lsu_ren, forward hit → RD_RESP. Data is latched from the youngest matching entry. An incoming same-cycle lsu_wen to the matching doubleword counts as youngest and is also pushed.
  - IDLE, lsu_ren, miss → RD_REQ.
  - IDLE, no lsu_ren, count > 0 → WR_REQ, presenting the head entry.
  - RD_REQ: dmem_req = 1, dmem_we = 0, dmem_addr = the latched lsu_raddr. On dmem_gnt → RD_WAIT. If dmem_rvalid arrives in the same cycle as dmem_gnt, go directly to RD_RESP.
  - RD_WAIT: on dmem_rvalid, latch dmem_rdata → RD_RESP.
  - RD_RESP: lsu_rvalid = 1 with the latched data, then → IDLE.
  - WR_REQ: dmem_req = 1, dmem_we = 1, head addr/data. On dmem_gnt, pop → IDLE.
- Load priority: a pending load beats draining, but only from IDLE. A drain already in WR_REQ completes first.
- Loads to addresses not in the buffer may bypass older buffered stores. Loads that match are always served by forwarding and never read memory.
- Stores are pushed in any state.
- Only one memory transaction is outstanding at a time.

## Timing
- Reset values: lsu_rvalid 0, lsu_rdata 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, sb_count 0, err_overflow 0, lsu_wready 1, FSM IDLE, pointers 0. Reset mid-transaction abandons it and empties the buffer.
- All outputs are registered or decoded from registered state. There is no combinational path from dmem_* inputs to dmem_req or lsu_wready.
- Forward hit latency: lsu_ren sampled at edge N → lsu_rvalid high during cycle N+1.
- Miss latency: ren at N → dmem_req from N+1. With grant at cycle G and rvalid at cycle R, lsu_rvalid is high in cycle R+1.
- Drain: the cycle after IDLE sees count > 0 with no ren, dmem_req rises. sb_count decrements the cycle after grant.
- Pointer wrap: tail and head wrap modulo SB_DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Simultaneous push and pop: count is unchanged.

## Test plan
- Store A=0x100 data 0x11 → single dmem write, addr 0x100, wdata 0x11. sb_count goes 1 → 0 one cycle after grant.
- Store 0x200←0xAA, then 0x200←0xBB, gnt held low, load 0x204 → lsu_rvalid one cycle later with 0xBB and no dmem read. Then both drains appear in order, 0xAA then 0xBB.
- Load 0x300 miss, gnt after 2 cycles, rvalid 3 cycles later with 0xDEAD → lsu_rvalid exactly one cycle after dmem_rvalid with 0xDEAD. dmem_addr is 0x300 throughout the request.
- Fill SB_DEPTH = 4 stores with gnt low → lsu_wready 0. A fifth store sets err_overflow and count stays 4. Release gnt → 4 in-order writes, and lsu_wready returns 1 one cycle after the first pop.
- Load miss pending in RD_WAIT while 2 stores arrive → both pushed. The load returns memory data, and drains start only after RD_RESP.
- Assert rst low in RD_WAIT with 3 buffered stores → all outputs return to reset values immediately. A dmem_rvalid arriving after reset release produces no lsu_rvalid.

Source files
------------

// File: rtl/lsu_mem_bridge.sv
// rtl/lsu_mem_bridge.sv - LSU-to-data-memory bridge with forwarding store buffer
module lsu_mem_bridge #(
    parameter int SB_DEPTH = 4,
    parameter int CNT_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_ren,
    input  logic [63:0]         lsu_raddr,
    output logic                lsu_rvalid,
    output logic [63:0]         lsu_rdata,
    input  logic                lsu_wen,
    input  logic [63:0]         lsu_waddr,
    input  logic [63:0]         lsu_wdata,
    output logic                lsu_wready,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [63:0]         dmem_addr,
    output logic [63:0]         dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [63:0]         dmem_rdata,
    output logic [CNT_BITS-1:0] sb_count,
    output logic                err_overflow
);

    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(SB_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_REQ
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_BITS-1:0] count_q;
    logic [60:0]         sb_addr_q [SB_DEPTH];
    logic [63:0]         sb_data_q [SB_DEPTH];
    logic                err_q;
    logic                rvalid_q;
    logic [63:0]         rdata_q;
    logic                req_q;
    logic                we_q;
    logic [63:0]         addr_q;
    logic [63:0]         wdata_q;

    logic                push, pop;
    logic                fwd_hit;
    logic [63:0]         fwd_data;
    logic [PTR_W-1:0]    fwd_idx;
    logic                unused_low_bits;

    assign lsu_wready   = (count_q < DEPTH_C);
    assign push         = lsu_wen && lsu_wready;
    assign pop          = (state_q == S_WR_REQ) && dmem_gnt;

    assign lsu_rvalid   = rvalid_q;
    assign lsu_rdata    = rdata_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign sb_count     = count_q;
    assign err_overflow = err_q;

    assign unused_low_bits = ^{lsu_raddr[2:0], lsu_waddr[2:0]};

    // Youngest matching entry wins: walk oldest to newest, then let a same-cycle store override
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_BITS'(i) < count_q) && (sb_addr_q[fwd_idx] == lsu_raddr[63:3])) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[fwd_idx];
            end
        end
        if (push && (lsu_waddr[63:3] == lsu_raddr[63:3])) begin
            fwd_hit  = 1'b1;
            fwd_data = lsu_wdata;
        end
    end

    // Store buffer pointers and occupancy; full/empty decided by count alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Store buffer payload; only entries inside [head, head+count) are ever consulted
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_q[tail_q] <= lsu_waddr[63:3];
            sb_data_q[tail_q] <= lsu_wdata;
        end
    end

    // Sticky record of a store dropped because the buffer was full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (lsu_wen && !lsu_wready) begin
            err_q <= 1'b1;
        end
    end

    // Access sequencer: loads win from IDLE, drains run one at a time, outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lsu_ren) begin
                        if (fwd_hit) begin
                            rdata_q  <= fwd_data;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RD_RESP;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= {lsu_raddr[63:3], 3'b000};
                            state_q <= S_RD_REQ;
                        end
                    end else if (count_q != '0) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= {sb_addr_q[head_q], 3'b000};
                        wdata_q <= sb_data_q[head_q];
                        state_q <= S_WR_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (dmem_gnt) begin
                        req_q <= 1'b0;
                        if (dmem_rvalid) begin
                            rdata_q  <= dmem_rdata;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RD_RESP;
                        end else begin
                            state_q <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (dmem_rvalid) begin
                        rdata_q  <= dmem_rdata;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    rvalid_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                S_WR_REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb/tb_lsu_mem_bridge.sv - self-checking bench for lsu_mem_bridge
module tb_lsu_mem_bridge;

    logic        clk;
    logic        rst;
    logic        lsu_ren;
    logic [63:0] lsu_raddr;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        lsu_wen;
    logic [63:0] lsu_waddr;
    logic [63:0] lsu_wdata;
    logic        lsu_wready;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic [2:0]  sb_count;
    logic        err_overflow;

    lsu_mem_bridge #(.SB_DEPTH(4), .CNT_BITS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_ren      (lsu_ren),
        .lsu_raddr    (lsu_raddr),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rdata    (lsu_rdata),
        .lsu_wen      (lsu_wen),
        .lsu_waddr    (lsu_waddr),
        .lsu_wdata    (lsu_wdata),
        .lsu_wready   (lsu_wready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .sb_count     (sb_count),
        .err_overflow (err_overflow)
    );

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;
    logic auto_gnt = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer as a queue of doublewords, one load tracked at a time
    typedef struct {
        logic [60:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_ovf;
    logic        m_load_active;
    logic        m_miss;
    logic        m_rd_granted;
    logic        m_resp_due;
    logic [63:0] m_data;
    logic [63:0] m_ld_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_load_active = 1'b0;
            m_miss = 1'b0;
            m_rd_granted = 1'b0;
            m_resp_due = 1'b0;
            m_data = '0;
            m_ld_addr = '0;
        end else begin
            logic pushed;
            ent_t ne;
            pushed = 1'b0;
            ne.a = lsu_waddr[63:3];
            ne.d = lsu_wdata;
            if (lsu_wen) begin
                if (mq.size() >= 4) m_ovf = 1'b1;
                else pushed = 1'b1;
            end
            if (dmem_req && dmem_we && dmem_gnt && mq.size() > 0) void'(mq.pop_front());
            if (m_resp_due) begin
                m_resp_due = 1'b0;
                m_load_active = 1'b0;
                m_miss = 1'b0;
                m_rd_granted = 1'b0;
            end else if (m_load_active && m_miss) begin
                if (dmem_req && !dmem_we && dmem_gnt) m_rd_granted = 1'b1;
                if (m_rd_granted && dmem_rvalid) begin
                    m_data = dmem_rdata;
                    m_resp_due = 1'b1;
                end
            end else if (!m_load_active && lsu_ren && !(dmem_req && dmem_we)) begin
                logic hit;
                hit = 1'b0;
                foreach (mq[i]) begin
                    if (mq[i].a == lsu_raddr[63:3]) begin
                        hit = 1'b1;
                        m_data = mq[i].d;
                    end
                end
                if (pushed && ne.a == lsu_raddr[63:3]) begin
                    hit = 1'b1;
                    m_data = ne.d;
                end
                m_load_active = 1'b1;
                m_miss = !hit;
                m_resp_due = hit;
                m_rd_granted = 1'b0;
                m_ld_addr = {lsu_raddr[63:3], 3'b000};
            end
            if (pushed) mq.push_back(ne);
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (checking && rst) begin
            chk("sb_count", 64'(sb_count), 64'(mq.size()));
            chk("wready", 64'(lsu_wready), 64'(mq.size() < 4));
            chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
            chk("rvalid", 64'(lsu_rvalid), 64'(m_resp_due));
            if (m_resp_due) chk("rdata", lsu_rdata, m_data);
            if (dmem_req && dmem_we) begin
                if (mq.size() == 0) chk("wr_entry_present", 64'(mq.size()), 64'd1);
                else begin
                    chk("wr_addr", dmem_addr, {mq[0].a, 3'b000});
                    chk("wr_data", dmem_wdata, mq[0].d);
                end
            end
            if (dmem_req && !dmem_we) begin
                chk("rd_only_on_miss", 64'(m_load_active && m_miss), 64'd1);
                chk("rd_addr", dmem_addr, m_ld_addr);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
        lsu_wen = 1'b0;
        dmem_rvalid = 1'b0;
        if (auto_gnt) dmem_gnt = dmem_req & dmem_we;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        lsu_wen = 1'b1;
        lsu_waddr = a;
        lsu_wdata = d;
        step();
    endtask

    task automatic wait_drain;
        for (int k = 0; k < 100 && sb_count != 0; k++) step();
        chk("drain_done", 64'(sb_count), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rvalid"}, 64'(lsu_rvalid), 64'd0);
        chk({tag, "_rdata"}, lsu_rdata, 64'd0);
        chk({tag, "_req"}, 64'(dmem_req), 64'd0);
        chk({tag, "_we"}, 64'(dmem_we), 64'd0);
        chk({tag, "_addr"}, dmem_addr, 64'd0);
        chk({tag, "_wdata"}, dmem_wdata, 64'd0);
        chk({tag, "_count"}, 64'(sb_count), 64'd0);
        chk({tag, "_ovf"}, 64'(err_overflow), 64'd0);
        chk({tag, "_wready"}, 64'(lsu_wready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        lsu_ren = 1'b0; lsu_raddr = '0;
        lsu_wen = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        step(); step();
        chk_reset_vals("reset");
        rst = 1'b1;
        checking = 1'b1;
        step();

        // single store drains as one write
        store(64'h100, 64'h11);
        chk("t1_count_push", 64'(sb_count), 64'd1);
        chk("t1_req_low", 64'(dmem_req), 64'd0);
        step();
        chk("t1_req", 64'(dmem_req), 64'd1);
        chk("t1_we", 64'(dmem_we), 64'd1);
        chk("t1_addr", dmem_addr, 64'h100);
        chk("t1_wdata", dmem_wdata, 64'h11);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t1_count_pop", 64'(sb_count), 64'd0);
        chk("t1_req_drop", 64'(dmem_req), 64'd0);

        // forward from youngest (same-cycle store), then in-order drains
        store(64'h200, 64'hAA);
        lsu_ren = 1'b1; lsu_raddr = 64'h204;
        store(64'h200, 64'hBB);
        chk("t2_fwd_rvalid", 64'(lsu_rvalid), 64'd1);
        chk("t2_fwd_rdata", lsu_rdata, 64'hBB);
        chk("t2_no_read", 64'(dmem_req), 64'd0);
        lsu_ren = 1'b0;
        step();
        chk("t2_rvalid_pulse", 64'(lsu_rvalid), 64'd0);
        chk("t2_count", 64'(sb_count), 64'd2);
        step();
        chk("t2_drain0_addr", dmem_addr, 64'h200);
        chk("t2_drain0_data", dmem_wdata, 64'hAA);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t2_count1", 64'(sb_count), 64'd1);
        step();
        chk("t2_drain1_data", dmem_wdata, 64'hBB);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t2_count0", 64'(sb_count), 64'd0);

        // load miss with delayed grant and delayed return
        lsu_ren = 1'b1; lsu_raddr = 64'h300;
        step();
        chk("t3_req", 64'(dmem_req), 64'd1);
        chk("t3_we", 64'(dmem_we), 64'd0);
        chk("t3_addr0", dmem_addr, 64'h300);
        step();
        chk("t3_addr1", dmem_addr, 64'h300);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t3_req_drop", 64'(dmem_req), 64'd0);
        step(); step();
        chk("t3_no_early_rvalid", 64'(lsu_rvalid), 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD;
        step();
        chk("t3_rvalid", 64'(lsu_rvalid), 64'd1);
        chk("t3_rdata", lsu_rdata, 64'hDEAD);
        lsu_ren = 1'b0;
        step();
        chk("t3_rvalid_pulse", 64'(lsu_rvalid), 64'd0);

        // fill, overflow, then release
        for (int i = 0; i < 4; i++) store(64'h400 + 64'(8 * i), 64'(i + 1));
        chk("t4_full_count", 64'(sb_count), 64'd4);
        chk("t4_wready_low", 64'(lsu_wready), 64'd0);
        chk("t4_no_ovf_yet", 64'(err_overflow), 64'd0);
        store(64'h420, 64'h5);
        chk("t4_ovf", 64'(err_overflow), 64'd1);
        chk("t4_count_stays", 64'(sb_count), 64'd4);
        chk("t4_head_addr", dmem_addr, 64'h400);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t4_count3", 64'(sb_count), 64'd3);
        chk("t4_wready_back", 64'(lsu_wready), 64'd1);
        auto_gnt = 1'b1;
        wait_drain();
        chk("t4_ovf_sticky", 64'(err_overflow), 64'd1);

        // stores accepted while a miss waits; drains only after the response
        lsu_ren = 1'b1; lsu_raddr = 64'h500;
        step();
        dmem_gnt = 1'b1; step();
        chk("t5_wait_req", 64'(dmem_req), 64'd0);
        store(64'h600, 64'h66);
        store(64'h608, 64'h77);
        chk("t5_count", 64'(sb_count), 64'd2);
        chk("t5_no_drain", 64'(dmem_req), 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'hBEEF;
        step();
        chk("t5_rvalid", 64'(lsu_rvalid), 64'd1);
        chk("t5_rdata", lsu_rdata, 64'hBEEF);
        lsu_ren = 1'b0;
        step();
        chk("t5_no_drain_resp", 64'(dmem_req), 64'd0);
        step();
        chk("t5_drain_start", 64'(dmem_req), 64'd1);
        chk("t5_drain_addr", dmem_addr, 64'h600);
        wait_drain();

        // reset in RD_WAIT with three buffered stores
        auto_gnt = 1'b0;
        dmem_gnt = 1'b0;
        lsu_ren = 1'b1; lsu_raddr = 64'h800;
        store(64'h700, 64'h7);
        store(64'h708, 64'h8);
        store(64'h710, 64'h9);
        dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
        chk("t6_count3", 64'(sb_count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        lsu_ren = 1'b0;
        step(); step();
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'h1234;
        step();
        chk("t6_no_rvalid0", 64'(lsu_rvalid), 64'd0);
        step();
        chk("t6_no_rvalid1", 64'(lsu_rvalid), 64'd0);
        chk("t6_no_req", 64'(dmem_req), 64'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
